// File: rtl/dmem_bus_bridge_if.sv
// Core-side 64-bit data-memory bus plus the 32-bit external SRAM bus, bundled.
// No logic of its own: the bridge owns all timing.
// Backpressure: the core waits on oStall, the bridge waits on iMemReady.
//
// Ports (as seen from the bridge, modport slave):
//   core side : iAddress, iReadEnable, iWriteEnable, iWriteData, iByteEnable in;
//               oReadData, oStall, oBusError out
//   SRAM side : oMemAddr, oMemRE, oMemWE, oMemBE, oMemWData out;
//               iMemRData, iMemReady in
// The master modport is the mirror image, used by whatever drives the core
// requests and models the SRAM.
interface dmem_bus_bridge_if #(
  parameter int MEM_AW = 32
);
  // core side
  logic [63:0]       iAddress;
  logic              iReadEnable;
  logic              iWriteEnable;
  logic [63:0]       iWriteData;
  logic [7:0]        iByteEnable;
  logic [63:0]       oReadData;
  logic              oStall;
  logic              oBusError;
  // external SRAM side
  logic [MEM_AW-1:0] oMemAddr;
  logic              oMemRE;
  logic              oMemWE;
  logic [3:0]        oMemBE;
  logic [31:0]       oMemWData;
  logic [31:0]       iMemRData;
  logic              iMemReady;

  modport slave (
    input  iAddress, iReadEnable, iWriteEnable, iWriteData, iByteEnable,
    input  iMemRData, iMemReady,
    output oReadData, oStall, oBusError,
    output oMemAddr, oMemRE, oMemWE, oMemBE, oMemWData
  );

  modport master (
    output iAddress, iReadEnable, iWriteEnable, iWriteData, iByteEnable,
    output iMemRData, iMemReady,
    input  oReadData, oStall, oBusError,
    input  oMemAddr, oMemRE, oMemWE, oMemBE, oMemWData
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// Bridges the core's 64-bit data-memory access onto a 32-bit wait-stated SRAM, low word then high word.
// Latency: request cycle + one cycle per beat plus its wait states, then a one-cycle DONE (data valid).
// Backpressure: oStall holds the core for the whole access; each beat waits for iMemReady.
//
// Ports:
//   iCLK  - clock, rising edge
//   iRST  - asynchronous reset, active low
//   bus   - dmem_bus_bridge_if.slave (core request/response and SRAM strobes)
// Parameters:
//   MEM_AW  - external word-address width
//   TIMEOUT - wait cycles per beat before the beat is abandoned (only with the macro below)
// Optional feature: define DMEM_BRIDGE_TIMEOUT_EN to enable the per-beat wait timeout
// and the sticky oBusError flag; otherwise beats wait forever and oBusError is 0.
module dmem_bus_bridge #(
  parameter int MEM_AW = 32
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input logic              iCLK,
  input logic              iRST,
  dmem_bus_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  // Everything the SRAM sees during one beat, registered as a unit.
  typedef struct packed {
    logic              re;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [MEM_AW-1:0] addr;
  } memBeat_t;

  state_t            state;
  logic              isWrite;
  logic [MEM_AW-2:0] pairAddr;   // address of the 64-bit word pair
  logic [63:0]       wdataReg;
  logic [7:0]        beReg;
  logic [63:0]       readData;
  memBeat_t          memOut;
  logic              request;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0]     waitCnt;
  logic              busError;
`endif

  // Byte-offset bits and address bits above the SRAM range are not used.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{bus.iAddress[63:MEM_AW+2], bus.iAddress[2:0]};

  assign request = bus.iReadEnable | bus.iWriteEnable;

  // Combinational in the request cycle so the PC cannot advance before the
  // bridge has taken the access; gated by reset so a held request does not
  // stall a core that is itself being reset.
  assign bus.oStall = iRST & (((state == IDLE) & request) | (state == LO) | (state == HI));

  assign bus.oReadData = readData;
  assign bus.oMemRE    = memOut.re;
  assign bus.oMemWE    = memOut.we;
  assign bus.oMemBE    = memOut.be;
  assign bus.oMemWData = memOut.wdata;
  assign bus.oMemAddr  = memOut.addr;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  assign bus.oBusError = busError;
`else
  assign bus.oBusError = 1'b0;
`endif

  // Build the SRAM drive for one half of the 64-bit access.
  function automatic memBeat_t mkBeat(input logic wr, input logic [MEM_AW-2:0] pa,
                                      input logic hi, input logic [63:0] wd,
                                      input logic [7:0] be);
    memBeat_t b;
    b.re    = ~wr;
    b.we    = wr;
    b.be    = hi ? be[7:4] : be[3:0];
    b.wdata = hi ? wd[63:32] : wd[31:0];
    b.addr  = {pa, hi};
    return b;
  endfunction

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state    <= IDLE;
      isWrite  <= 1'b0;
      pairAddr <= '0;
      wdataReg <= '0;
      beReg    <= '0;
      readData <= '0;
      memOut   <= '0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      waitCnt  <= '0;
      busError <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            // A write wins over a simultaneous read.
            isWrite  <= bus.iWriteEnable;
            pairAddr <= bus.iAddress[MEM_AW+1:3];
            wdataReg <= bus.iWriteData;
            beReg    <= bus.iByteEnable;
            readData <= '0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
            waitCnt  <= '0;
`endif
            if (|bus.iByteEnable[3:0]) begin
              state  <= LO;
              memOut <= mkBeat(bus.iWriteEnable, bus.iAddress[MEM_AW+1:3], 1'b0,
                               bus.iWriteData, bus.iByteEnable);
            end else if (|bus.iByteEnable[7:4]) begin
              state  <= HI;
              memOut <= mkBeat(bus.iWriteEnable, bus.iAddress[MEM_AW+1:3], 1'b1,
                               bus.iWriteData, bus.iByteEnable);
            end else begin
              // No lanes enabled: complete without touching the SRAM.
              state <= DONE;
            end
          end
        end

        LO, HI: begin
          if (bus.iMemReady) begin
            if (!isWrite) begin
              if (state == LO) readData[31:0]  <= bus.iMemRData;
              else             readData[63:32] <= bus.iMemRData;
            end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
            waitCnt <= '0;
`endif
            if ((state == LO) && (|beReg[7:4])) begin
              state  <= HI;
              memOut <= mkBeat(isWrite, pairAddr, 1'b1, wdataReg, beReg);
            end else begin
              state  <= DONE;
              memOut <= '0;
            end
          end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
          else if (waitCnt == CW'(TIMEOUT - 1)) begin
            // Abandon the access; data for this beat stays zero and any
            // remaining beat is skipped.
            state    <= DONE;
            memOut   <= '0;
            busError <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
`endif
        end

        // Response cycle: readData is valid here; a request still held is
        // deliberately not captured until the next IDLE cycle.
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: a driver issues core accesses and
// pushes expected beats/read data/stall lengths; a monitor checks SRAM beats
// as they complete and the response when the access finishes.
module tb_dmem_bus_bridge;

  localparam int MEM_AW = 32;

  logic iCLK = 1'b0;
  logic iRST;
  always #5 iCLK = ~iCLK;

  dmem_bus_bridge_if #(.MEM_AW(MEM_AW)) bus ();

  dmem_bus_bridge #(
    .MEM_AW(MEM_AW)
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  beat_t       beatQ[$];
  logic [63:0] rdQ[$];
  int          stallQ[$];

  int errors = 0;
  int checks = 0;

  logic [31:0] sram   [int unsigned];  // what the SRAM model actually holds
  logic [31:0] refMem [int unsigned];  // what the reference says it should hold

  int   memMode = 0;    // 0 random waits, 1 fixed memWait waits, 2 ready only on low word
  int   memWait = 0;
  bit   skipMon = 1'b0;
  logic expBusErr = 1'b0;

  function automatic logic [31:0] dflt(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] sramGet(input logic [31:0] wa);
    return sram.exists(wa) ? sram[wa] : dflt(wa);
  endfunction

  function automatic logic [31:0] refGet(input logic [31:0] wa);
    return refMem.exists(wa) ? refMem[wa] : dflt(wa);
  endfunction

  task automatic preset(input logic [31:0] wa, input logic [31:0] val);
    sram[wa]   = val;
    refMem[wa] = val;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finishRun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // SRAM model: ready and read data are updated just after each rising edge.
  initial begin : responder
    int   waited;
    logic lastStrobe;
    logic lastReady;
    logic rdy;
    waited = 0; lastStrobe = 1'b0; lastReady = 1'b0;
    bus.iMemReady = 1'b0;
    bus.iMemRData = '0;
    forever begin
      @(posedge iCLK);
      if (lastStrobe && lastReady) waited = 0;
      else if (lastStrobe)         waited++;
      else                         waited = 0;
      #1;
      lastStrobe = bus.oMemRE | bus.oMemWE;
      case (memMode)
        1:       rdy = (waited >= memWait);
        2:       rdy = ~bus.oMemAddr[0];
        default: rdy = (waited >= 5) || ($urandom_range(0, 3) != 0);
      endcase
      bus.iMemReady = rdy;
      lastReady     = rdy;
      bus.iMemRData = sramGet(bus.oMemAddr);
    end
  end

  // SRAM write port: a write beat lands on the edge where ready is high.
  initial begin : sramWriter
    logic [31:0] w;
    forever begin
      @(negedge iCLK);
      if (iRST && bus.oMemWE && bus.iMemReady) begin
        w = sramGet(bus.oMemAddr);
        for (int k = 0; k < 4; k++)
          if (bus.oMemBE[k]) w[8*k +: 8] = bus.oMemWData[8*k +: 8];
        sram[bus.oMemAddr] = w;
      end
    end
  end

  // Monitor: checks beats, strobe stability and the DONE-cycle response.
  initial begin : monitor
    logic        prevStall;
    int          stallRun;
    logic        lastWaiting;
    beat_t       lastBeat;
    beat_t       cur;
    beat_t       exp;
    logic [63:0] expRd;
    int          expStall;
    prevStall = 1'b0; stallRun = 0; lastWaiting = 1'b0; lastBeat = '0;
    forever begin
      @(negedge iCLK);
      cur.addr  = bus.oMemAddr;
      cur.re    = bus.oMemRE;
      cur.we    = bus.oMemWE;
      cur.be    = bus.oMemBE;
      cur.wdata = bus.oMemWData;
      if (skipMon || !iRST) begin
        prevStall   = bus.oStall;
        stallRun    = 0;
        lastWaiting = 1'b0;
      end else begin
        if (lastWaiting) check("strobe_hold", cur, lastBeat);
        if (cur.re | cur.we) begin
          if (bus.iMemReady) begin
            check("beat_pending", 128'(beatQ.size() > 0), 1);
            if (beatQ.size() > 0) begin
              exp = beatQ.pop_front();
              check("beat", cur, exp);
            end
          end
          lastWaiting = ~bus.iMemReady;
          lastBeat    = cur;
        end else begin
          lastWaiting = 1'b0;
        end
        if (bus.oStall) stallRun++;
        if (prevStall && !bus.oStall) begin
          check("done_pending", 128'(rdQ.size()), 1);
          if (rdQ.size() > 0) begin
            expRd    = rdQ.pop_front();
            expStall = stallQ.pop_front();
            check("read_data", bus.oReadData, expRd);
            if (expStall >= 0) check("stall_cycles", 128'(stallRun), 128'(expStall));
          end
          check("bus_error", bus.oBusError, expBusErr);
          check("beats_left", 128'(beatQ.size()), 0);
          stallRun = 0;
        end
        prevStall = bus.oStall;
      end
    end
  end

  task automatic idleInputs();
    bus.iReadEnable  = 1'b0;
    bus.iWriteEnable = 1'b0;
    bus.iAddress     = '0;
    bus.iWriteData   = '0;
    bus.iByteEnable  = '0;
  endtask

  // Issue one core access at posedge+1; returns at posedge+1 after DONE.
  // toCase: the access is expected to time out on its first beat.
  task automatic issue(input logic re, input logic we, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [7:0] be,
                       input bit noise, input bit toCase);
    logic [63:0] pairIdx;
    logic [31:0] wa0;
    logic [31:0] w;
    logic [63:0] expRd;
    beat_t       b;
    int          nb;
    int          cnt;
    pairIdx = (addr >> 3) * 2;
    wa0     = pairIdx[31:0];
    expRd   = '0;
    nb      = 0;
    if (!toCase) begin
      for (int h = 0; h < 2; h++) begin
        if (be[4*h +: 4] != 4'h0) begin
          b.addr  = wa0 + 32'(h);
          b.re    = ~we;
          b.we    = we;
          b.be    = be[4*h +: 4];
          b.wdata = wd[32*h +: 32];
          beatQ.push_back(b);
          nb++;
          if (we) begin
            w = refGet(b.addr);
            for (int k = 0; k < 4; k++)
              if (be[4*h + k]) w[8*k +: 8] = wd[32*h + 8*k +: 8];
            refMem[b.addr] = w;
          end else begin
            expRd[32*h +: 32] = refGet(b.addr);
          end
        end
      end
    end
    rdQ.push_back(expRd);
    if (toCase)            stallQ.push_back(9);
    else if (memMode == 1) stallQ.push_back(1 + nb * (1 + memWait));
    else                   stallQ.push_back(-1);

    bus.iReadEnable  = re;
    bus.iWriteEnable = we;
    bus.iAddress     = addr;
    bus.iWriteData   = wd;
    bus.iByteEnable  = be;
    @(negedge iCLK);
    check("stall_req", bus.oStall, 1);
    cnt = 0;
    forever begin
      @(posedge iCLK);
      #1;
      if (noise) begin
        bus.iReadEnable  = 1'($urandom_range(0, 1));
        bus.iWriteEnable = 1'($urandom_range(0, 1));
        bus.iAddress     = {$urandom, $urandom};
        bus.iWriteData   = {$urandom, $urandom};
        bus.iByteEnable  = 8'($urandom);
      end
      @(negedge iCLK);
      cnt++;
      if (!bus.oStall) break;
      if (cnt > 500) begin
        check("access_timeout", bus.oStall, 0);
        finishRun();
      end
    end
    @(posedge iCLK);
    #1;
    idleInputs();
  endtask

  initial begin : driver
    logic [63:0] a;
    logic [7:0]  be;
    logic        re;
    logic        we;
    int          cnt;
    iRST = 1'b0;
    idleInputs();
    repeat (2) @(posedge iCLK);
    #1;
    check("rst_readdata", bus.oReadData, 0);
    check("rst_stall",    bus.oStall, 0);
    check("rst_buserr",   bus.oBusError, 0);
    check("rst_memre",    bus.oMemRE, 0);
    check("rst_memwe",    bus.oMemWE, 0);
    check("rst_membe",    bus.oMemBE, 0);
    check("rst_memaddr",  bus.oMemAddr, 0);
    check("rst_memwdata", bus.oMemWData, 0);
    @(negedge iCLK);
    iRST = 1'b1;
    @(posedge iCLK);
    #1;

    // Ready tied high: full read, 0x1008 -> words 0x402/0x403.
    memMode = 1; memWait = 0;
    preset(32'h402, 32'h11111111);
    preset(32'h403, 32'h22222222);
    issue(1'b1, 1'b0, 64'h1008, 64'h0, 8'hFF, 1'b0, 1'b0);
    // High-half-only write: one beat at word 0x5 with BE 0x3.
    issue(1'b0, 1'b1, 64'h10, 64'h0000_AABB_0000_0000, 8'h30, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 64'h10, 64'h0, 8'hFF, 1'b0, 1'b0);
    // Four wait states on a low-only read.
    memWait = 4;
    issue(1'b1, 1'b0, 64'h1008, 64'h0, 8'h0F, 1'b0, 1'b0);
    memWait = 0;
    // Read and write together: write only, no read data.
    issue(1'b1, 1'b1, 64'h18, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 64'h18, 64'h0, 8'hC3, 1'b0, 1'b0);
    // No lanes: completes with no beats.
    issue(1'b1, 1'b0, 64'h20, 64'h0, 8'h00, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0, 1'b0);

    // Randomized traffic with random wait states and input noise mid-access.
    memMode = 0;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      re = we ? 1'($urandom_range(0, 1)) : 1'b1;
      case ($urandom_range(0, 5))
        0:       be = 8'h00;
        1:       be = 8'h0F;
        2:       be = 8'hF0;
        3:       be = 8'hFF;
        default: be = 8'($urandom);
      endcase
      a = {$urandom, $urandom};
      a[33:3] = 31'($urandom_range(0, 15));
      issue(re, we, a, {$urandom, $urandom}, be, ($urandom_range(0, 1) == 1), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge iCLK);
        #1;
      end
    end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    // Memory never ready: the low beat is abandoned after 8 wait cycles.
    memMode = 1; memWait = 100000;
    expBusErr = 1'b1;
    issue(1'b1, 1'b0, 64'h40, 64'h0, 8'h0F, 1'b0, 1'b1);
    memWait = 0;
`endif

    // Reset while the high beat of a read is waiting.
    skipMon = 1'b1;
    memMode = 2;
    bus.iReadEnable = 1'b1;
    bus.iAddress    = 64'h48;
    bus.iByteEnable = 8'hFF;
    cnt = 0;
    do begin
      @(negedge iCLK);
      cnt++;
    end while (!(bus.oMemRE && bus.oMemAddr[0]) && cnt < 50);
    if (cnt >= 50) begin
      check("hi_beat_reached", bus.oMemAddr[0], 1);
      finishRun();
    end
    repeat (2) @(negedge iCLK);
    #2;
    iRST = 1'b0;
    #1;
    check("arst_memre",    bus.oMemRE, 0);
    check("arst_memwe",    bus.oMemWE, 0);
    check("arst_membe",    bus.oMemBE, 0);
    check("arst_memaddr",  bus.oMemAddr, 0);
    check("arst_memwdata", bus.oMemWData, 0);
    check("arst_stall",    bus.oStall, 0);
    check("arst_readdata", bus.oReadData, 0);
    check("arst_buserr",   bus.oBusError, 0);
    @(negedge iCLK);
    idleInputs();
    iRST = 1'b1;
    memMode = 1; memWait = 0;
    expBusErr = 1'b0;
    @(posedge iCLK);
    #1;
    skipMon = 1'b0;
    issue(1'b1, 1'b0, 64'h1008, 64'h0, 8'hFF, 1'b0, 1'b0);

    repeat (3) @(posedge iCLK);
    #1;
    check("queue_drain", 128'(rdQ.size() + beatQ.size()), 0);
    finishRun();
  end

endmodule
